// File: rtl/gpio_input_responder.sv
// gpio_input_responder: memory-mapped GPIO input peripheral.
// Synchronises and debounces WIDTH pins, latches rising edges in sticky
// flags and answers bus reads with a one-cycle-latency response.
// Registers: +0 LEVEL (RO), +4 EDGE (read-clears, W1C), +8 MASK (optional).
// Optional feature macro: GPIO_INPUT_IRQ_EN adds the MASK register and irq.
module gpio_input_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h00000404,
  parameter int          WIDTH           = 8,
  parameter int          DEBOUNCE_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_in,
  input  logic             bus_address_valid,
  input  logic [31:0]      bus_address_payload,
  input  logic             bus_write,
  input  logic [31:0]      bus_data_payload,
  output logic             rsp_valid,
  output logic [31:0]      rsp_payload
`ifdef GPIO_INPUT_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [29:0] LEVEL_WORD = BASE_ADDR[31:2];
  localparam logic [29:0] EDGE_WORD  = BASE_ADDR[31:2] + 30'd1;
  localparam logic [15:0] CNT_MAX    = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_next;
  logic [WIDTH-1:0] rise;
  logic [15:0]      cnt      [WIDTH];
  logic [15:0]      cnt_next [WIDTH];
  logic [WIDTH-1:0] edge_flags;
  logic [WIDTH-1:0] edge_clr;
  logic [29:0]      word;
  logic             rd_req;
  logic             wr_req;
  logic             hit_level;
  logic             hit_edge;
  logic             read_hit;
  logic [31:0]      rd_data;
  logic             unused_bits;

  // Byte-lane bits are ignored and upper write-data bits have no storage.
  assign unused_bits = ^{bus_address_payload[1:0], bus_data_payload};

  assign word      = bus_address_payload[31:2];
  assign rd_req    = bus_address_valid & ~bus_write;
  assign wr_req    = bus_address_valid & bus_write;
  assign hit_level = (word == LEVEL_WORD);
  assign hit_edge  = (word == EDGE_WORD);

`ifdef GPIO_INPUT_IRQ_EN
  localparam logic [29:0] MASK_WORD = BASE_ADDR[31:2] + 30'd2;
  logic [WIDTH-1:0] mask;
  logic             hit_mask;
  assign hit_mask = (word == MASK_WORD);
  assign read_hit = rd_req & (hit_level | hit_edge | hit_mask);
`else
  assign read_hit = rd_req & (hit_level | hit_edge);
`endif

  // Two-flop synchroniser; the only logic that sees raw io_in.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= io_in;
      s2 <= s1;
    end
  end

  // Per-bit debounce: count consecutive disagreeing cycles, adopt on the last.
  always_comb begin
    db_next = db;
    rise    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != db[i]) begin
        if (cnt[i] == CNT_MAX) begin
          db_next[i] = s2[i];
          rise[i]    = s2[i];
        end else begin
          cnt_next[i] = cnt[i] + 16'd1;
        end
      end
    end
  end

  // Debounced level and counters; reset discards any partial count.
  always_ff @(posedge clk) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      db <= db_next;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

  // Clear sources for the edge flags: an EDGE read clears all, a write clears ones.
  always_comb begin
    edge_clr = '0;
    if (hit_edge && rd_req) edge_clr = '1;
    else if (hit_edge && wr_req) edge_clr = bus_data_payload[WIDTH-1:0];
  end

  // Sticky rising-edge flags; a new edge wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) edge_flags <= '0;
    else       edge_flags <= (edge_flags & ~edge_clr) | rise;
  end

  // Read mux over the current register contents, upper bits zero.
  always_comb begin
    rd_data = '0;
    if (hit_level) rd_data[WIDTH-1:0] = db;
    if (hit_edge)  rd_data[WIDTH-1:0] = edge_flags;
`ifdef GPIO_INPUT_IRQ_EN
    if (hit_mask)  rd_data[WIDTH-1:0] = mask;
`endif
  end

  // One-cycle response; payload holds its last value between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid   <= 1'b0;
      rsp_payload <= '0;
    end else begin
      rsp_valid <= read_hit;
      if (read_hit) rsp_payload <= rd_data;
    end
  end

`ifdef GPIO_INPUT_IRQ_EN
  // Interrupt mask register, read/write.
  always_ff @(posedge clk) begin
    if (reset)                    mask <= '0;
    else if (wr_req && hit_mask)  mask <= bus_data_payload[WIDTH-1:0];
  end

  // Registered interrupt from any unmasked pending edge.
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(edge_flags & mask);
  end
`endif

endmodule

// File: tb/tb_gpio_input_responder.sv
// Bench for gpio_input_responder with WIDTH=8, DEBOUNCE_CYCLES=4,
// BASE_ADDR=0x404. Expected responses go into a queue at issue time and are
// popped by a monitor whenever rsp_valid is seen.
module tb_gpio_input_responder;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  io_in = '0;
  logic        bus_address_valid = 1'b0;
  logic [31:0] bus_address_payload = '0;
  logic        bus_write = 1'b0;
  logic [31:0] bus_data_payload = '0;
  logic        rsp_valid;
  logic [31:0] rsp_payload;
`ifdef GPIO_INPUT_IRQ_EN
  logic        irq;
`endif

  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  exp_t sb[$];

  gpio_input_responder #(
    .BASE_ADDR(32'h00000404),
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io_in(io_in),
    .bus_address_valid(bus_address_valid),
    .bus_address_payload(bus_address_payload),
    .bus_write(bus_write),
    .bus_data_payload(bus_data_payload),
    .rsp_valid(rsp_valid),
    .rsp_payload(rsp_payload)
`ifdef GPIO_INPUT_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Cycle counter used to timestamp expected responses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // One bus request lasting one cycle; a read hit queues its expected response.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic exp_rsp,
                               input logic [31:0] exp_data);
    exp_t e;
    bus_address_valid   = 1'b1;
    bus_write           = wr;
    bus_address_payload = addr;
    bus_data_payload    = data;
    if (exp_rsp) begin
      e.data = exp_data;
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus_address_valid = 1'b0;
    bus_write         = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Every response must match the oldest queued expectation in data and timing.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", rsp_payload, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rsp_payload", rsp_payload, e.data);
        checkOutput("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tick(3);
    reset = 1'b0;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_payload", rsp_payload, 32'd0);

    // Read after reset, then a write that must not respond.
    applyStimulus(1'b0, 32'h404, 32'h0, 1'b1, 32'h0);
    applyStimulus(1'b1, 32'h404, 32'hFFFFFFFF, 1'b0, 32'h0);
    tick(2);

    // Step to 0x05: LEVEL read every cycle, 0 until cycle 6.
    io_in = 8'h05;
    for (int c = 0; c < 8; c++)
      applyStimulus(1'b0, 32'h404, 32'h0, 1'b1, (c >= 6) ? 32'h05 : 32'h00);

    // Three-cycle glitch on bit 7 never reaches LEVEL.
    io_in = 8'h85;
    tick(3);
    io_in = 8'h05;
    tick(8);
    applyStimulus(1'b0, 32'h404, 32'h0, 1'b1, 32'h05);

    // EDGE read returns and clears.
    applyStimulus(1'b0, 32'h408, 32'h0, 1'b1, 32'h05);
    applyStimulus(1'b0, 32'h408, 32'h0, 1'b1, 32'h00);

    // W1C clears the bit 1 edge.
    io_in = 8'h07;
    tick(6);
    applyStimulus(1'b1, 32'h408, 32'h02, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h408, 32'h0, 1'b1, 32'h00);
    applyStimulus(1'b0, 32'h404, 32'h0, 1'b1, 32'h07);

    // EDGE read in the cycle bit 3 debounces high: set wins.
    io_in = 8'h0F;
    tick(5);
    applyStimulus(1'b0, 32'h408, 32'h0, 1'b1, 32'h00);
    applyStimulus(1'b0, 32'h408, 32'h0, 1'b1, 32'h08);

    // Misses, ignored byte lanes, back-to-back reads.
    applyStimulus(1'b0, 32'h400, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h410, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h00000C04, 32'h0, 1'b0, 32'h0);
`ifndef GPIO_INPUT_IRQ_EN
    applyStimulus(1'b0, 32'h40C, 32'h0, 1'b0, 32'h0);
`endif
    applyStimulus(1'b0, 32'h406, 32'h0, 1'b1, 32'h0F);
    applyStimulus(1'b0, 32'h404, 32'h0, 1'b1, 32'h0F);
    applyStimulus(1'b0, 32'h408, 32'h0, 1'b1, 32'h00);

    // Falling bit 0 changes LEVEL but raises no edge.
    io_in = 8'h0E;
    tick(8);
    applyStimulus(1'b0, 32'h408, 32'h0, 1'b1, 32'h00);
    applyStimulus(1'b0, 32'h404, 32'h0, 1'b1, 32'h0E);

    // Clean restart, then reset mid-debounce with a coincident read.
    reset = 1'b1;
    io_in = 8'h00;
    tick(3);
    reset = 1'b0;
    io_in = 8'h10;
    tick(4);
    reset = 1'b1;
    applyStimulus(1'b0, 32'h404, 32'h0, 1'b0, 32'h0);
    reset = 1'b0;
    tick(5);
    applyStimulus(1'b0, 32'h404, 32'h0, 1'b1, 32'h00);
    applyStimulus(1'b0, 32'h404, 32'h0, 1'b1, 32'h10);
    applyStimulus(1'b0, 32'h408, 32'h0, 1'b1, 32'h10);

`ifdef GPIO_INPUT_IRQ_EN
    // Masked edge on bit 0 raises irq; EDGE read drops it.
    applyStimulus(1'b1, 32'h40C, 32'h01, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h40C, 32'h0, 1'b1, 32'h01);
    io_in = 8'h11;
    tick(6);
    checkOutput("irq_before", 32'(irq), 32'd0);
    tick(1);
    checkOutput("irq_set", 32'(irq), 32'd1);
    applyStimulus(1'b0, 32'h408, 32'h0, 1'b1, 32'h01);
    checkOutput("irq_hold", 32'(irq), 32'd1);
    tick(1);
    checkOutput("irq_clear", 32'(irq), 32'd0);
    applyStimulus(1'b1, 32'h40C, 32'h00, 1'b0, 32'h0);
    io_in = 8'h15;
    tick(8);
    checkOutput("irq_masked", 32'(irq), 32'd0);
    applyStimulus(1'b0, 32'h408, 32'h0, 1'b1, 32'h04);
`endif

    tick(3);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
